btb_maint_ctrl: RTL and testbench
=================================

Name: btb_maint_ctrl

Overview:
Maintenance controller and write-port arbiter for the 512-entry branch target buffer.
- After reset, and on a software flush request, it walks every BTB entry and writes it invalid (all zeros).
- It gates the BTB lookup enable until the clear has completed and the BTB's two pipeline stages have drained.
- In normal operation it passes EX-stage update writes through to the single BTB write port.
- It holds the branch statistics counters and provides a read-select interface to them.

Parameters:
DEPTH, 512, number of BTB entries; must be a power of two.
IDX_W, 9, index width; equals log2(DEPTH).
DATA_W, 25, entry width: tag[24:18], strong[17], valid[16], target[15:0].
CNT_W, 16, width of each statistics counter.
SETTLE_CYC, 2, cycles lookup stays disabled after the last clear write (IF_ID and ID_EX stages).

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
flush_req  in  1  single-cycle request to invalidate the whole BTB.
upd_we  in  1  BTB update write request from EX-stage allocate/evict/strong logic.
upd_idx  in  IDX_W  update write index.
upd_wdata  in  DATA_W  update write data.
inc_br_cnt  in  1  branch reached EX.
inc_hit_cnt  in  1  BTB hit this cycle.
inc_mispr_cnt  in  1  misprediction resolved in EX.
stat_sel  in  2  counter select: 0=branch, 1=hit, 2=mispredict, 3=dropped updates.
stat_clr  in  1  synchronous clear of all four counters.
mem_we  out  1  BTB write enable.
mem_idx  out  IDX_W  BTB write index.
mem_wdata  out  DATA_W  BTB write data.
btb_en  out  1  BTB lookup enable; a hit is only allowed when high.
flush_busy  out  1  high while in FLUSH or SETTLE.
flush_done  out  1  one-cycle pulse on the SETTLE->RUN transition.
stat_rdata  out  CNT_W  selected counter value, combinational from stat_sel.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- FSM states: FLUSH, SETTLE, RUN.
- Reset values: state=FLUSH, ptr=0, settle_cnt=0, all counters=0, btb_en=0, flush_busy=1, flush_done=0.
- The BTB is cleared automatically after every reset.

FLUSH state:
- Combinationally drives mem_we=1, mem_idx=ptr, mem_wdata=0. The BTB samples these on the negedge of the same cycle.
- ptr increments by 1 each posedge.
- When ptr==DEPTH-1: next state is SETTLE, ptr wraps to 0, settle_cnt=0.
- upd_we is ignored. If upd_we is high, the drop counter increments.
- flush_req while in FLUSH restarts the walk: ptr=0, state stays FLUSH.

SETTLE state:
- mem_we=0, btb_en=0.
- settle_cnt increments each cycle.
- When settle_cnt==SETTLE_CYC-1: next state is RUN, with a flush_done pulse in the first RUN cycle.
- upd_we is dropped and counted, as in FLUSH.
- flush_req moves to FLUSH with ptr=0.

RUN state:
- btb_en=1, flush_busy=0.
- mem_we=upd_we, mem_idx=upd_idx, mem_wdata=upd_wdata. This is a combinational pass-through with zero latency.
- flush_req moves to FLUSH with ptr=0.
- When flush_req and upd_we are both high in the same cycle, the update is still written that cycle (state is still RUN). The flush then overwrites it.

Outputs and timing:
- btb_en and flush_busy are registered, decoded from next state, so they change on the same posedge as the state.
- Timing from reset release: first clear write in cycle 0, last write (index 511) in cycle 511, SETTLE in cycles 512-513, btb_en=1 from cycle 514.

Counters:
- Each counter adds 1 when its increment input is high and saturates at 2^CNT_W-1 (no wrap).
- stat_clr has priority over increments in the same cycle.
- Counters operate in every FSM state. They are not cleared by flush_req.

Reset mid-operation:
- Reset asserted at any time immediately forces the reset values and restarts the clear from index 0.

Test Plan:
- Release rst_n, no other stimulus -> mem_we=1 with mem_idx 0..511 on consecutive cycles, mem_wdata=0; btb_en rises on cycle 514; flush_done pulses exactly once, in that cycle.
- In RUN, upd_we=1, upd_idx=0x07F, upd_wdata=0x0A_5123 -> mem_we=1, mem_idx=0x07F, mem_wdata=0x0A_5123 in the same cycle.
- flush_req in RUN, then a second flush_req 100 cycles later -> walk restarts at index 0; btb_en=0 throughout; total 100+512+2 cycles until btb_en=1.
- upd_we held high for 5 cycles during FLUSH, then stat_sel=3 -> stat_rdata=5; no update data is ever seen on mem_wdata.
- Pulse inc_hit_cnt 70000 times with CNT_W=16 -> stat_rdata saturates at 0xFFFF. Then stat_clr and inc_hit_cnt together -> hit counter reads 0.
- Assert rst_n low at ptr=300 during FLUSH -> outputs return to reset values immediately; after release the walk restarts at index 0.

Source files
------------

// File: rtl/btb_maint_ctrl.sv
// BTB maintenance controller: clears every entry after reset or flush, gates lookup
// until the pipeline drains, arbitrates the single BTB write port and keeps branch statistics.
module btb_maint_ctrl #(
    parameter int DEPTH      = 512,
    parameter int IDX_W      = 9,
    parameter int DATA_W     = 25,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_req,
    input  logic              upd_we,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic [DATA_W-1:0] upd_wdata,
    input  logic              inc_br_cnt,
    input  logic              inc_hit_cnt,
    input  logic              inc_mispr_cnt,
    input  logic [1:0]        stat_sel,
    input  logic              stat_clr,
    output logic              mem_we,
    output logic [IDX_W-1:0]  mem_idx,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              btb_en,
    output logic              flush_busy,
    output logic              flush_done,
    output logic [CNT_W-1:0]  stat_rdata
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [SET_W-1:0]   settle_cnt;
    logic [CNT_W-1:0]   cnt_br;
    logic [CNT_W-1:0]   cnt_hit;
    logic [CNT_W-1:0]   cnt_mispr;
    logic [CNT_W-1:0]   cnt_drop;
    logic               drop_upd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (!inc || (&v))
            return v;
        return v + CNT_W'(1);
    endfunction

    // btb_en/flush_busy/flush_done are decoded from the next state so they move with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FLUSH;
            ptr        <= '0;
            settle_cnt <= '0;
            btb_en     <= 1'b0;
            flush_busy <= 1'b1;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                ST_FLUSH: begin
                    btb_en     <= 1'b0;
                    flush_busy <= 1'b1;
                    if (flush_req) begin
                        ptr <= '0;
                    end else if (ptr == IDX_W'(DEPTH - 1)) begin
                        state      <= ST_SETTLE;
                        ptr        <= '0;
                        settle_cnt <= '0;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (flush_req) begin
                        state      <= ST_FLUSH;
                        ptr        <= '0;
                        btb_en     <= 1'b0;
                        flush_busy <= 1'b1;
                    end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                        state      <= ST_RUN;
                        btb_en     <= 1'b1;
                        flush_busy <= 1'b0;
                        flush_done <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                        btb_en     <= 1'b0;
                        flush_busy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state      <= ST_FLUSH;
                        ptr        <= '0;
                        btb_en     <= 1'b0;
                        flush_busy <= 1'b1;
                    end else begin
                        btb_en     <= 1'b1;
                        flush_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_FLUSH;
                    ptr        <= '0;
                    btb_en     <= 1'b0;
                    flush_busy <= 1'b1;
                end
            endcase
        end
    end

    // The BTB samples the write port on the falling edge, so these stay combinational.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        case (state)
            ST_FLUSH: begin
                mem_we  = 1'b1;
                mem_idx = ptr;
            end
            ST_RUN: begin
                mem_we    = upd_we;
                mem_idx   = upd_idx;
                mem_wdata = upd_wdata;
            end
            default: ;
        endcase
    end

    assign drop_upd = upd_we && (state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_br    <= '0;
            cnt_hit   <= '0;
            cnt_mispr <= '0;
            cnt_drop  <= '0;
        end else if (stat_clr) begin
            cnt_br    <= '0;
            cnt_hit   <= '0;
            cnt_mispr <= '0;
            cnt_drop  <= '0;
        end else begin
            cnt_br    <= sat_inc(cnt_br, inc_br_cnt);
            cnt_hit   <= sat_inc(cnt_hit, inc_hit_cnt);
            cnt_mispr <= sat_inc(cnt_mispr, inc_mispr_cnt);
            cnt_drop  <= sat_inc(cnt_drop, drop_upd);
        end
    end

    always_comb begin
        stat_rdata = cnt_br;
        case (stat_sel)
            2'd0:    stat_rdata = cnt_br;
            2'd1:    stat_rdata = cnt_hit;
            2'd2:    stat_rdata = cnt_mispr;
            default: stat_rdata = cnt_drop;
        endcase
    end

endmodule

// File: tb/tb_btb_maint_ctrl.sv
// Directed bench for btb_maint_ctrl: clear walk timing, update pass-through,
// flush restart, drop counting, counter saturation/clear and mid-walk reset.
module tb_btb_maint_ctrl;

    localparam int IDX_W  = 9;
    localparam int DATA_W = 25;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              flush_req;
    logic              upd_we;
    logic [IDX_W-1:0]  upd_idx;
    logic [DATA_W-1:0] upd_wdata;
    logic              inc_br_cnt;
    logic              inc_hit_cnt;
    logic              inc_mispr_cnt;
    logic [1:0]        stat_sel;
    logic              stat_clr;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic              btb_en;
    logic              flush_busy;
    logic              flush_done;
    logic [CNT_W-1:0]  stat_rdata;

    int total = 0;
    int bad   = 0;

    btb_maint_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_req    (flush_req),
        .upd_we       (upd_we),
        .upd_idx      (upd_idx),
        .upd_wdata    (upd_wdata),
        .inc_br_cnt   (inc_br_cnt),
        .inc_hit_cnt  (inc_hit_cnt),
        .inc_mispr_cnt(inc_mispr_cnt),
        .stat_sel     (stat_sel),
        .stat_clr     (stat_clr),
        .mem_we       (mem_we),
        .mem_idx      (mem_idx),
        .mem_wdata    (mem_wdata),
        .btb_en       (btb_en),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done),
        .stat_rdata   (stat_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int errs, rise, ndone, done_cyc;
        rst_n = 0; flush_req = 0; upd_we = 0; upd_idx = '0; upd_wdata = '0;
        inc_br_cnt = 0; inc_hit_cnt = 0; inc_mispr_cnt = 0; stat_sel = 2'd0; stat_clr = 0;

        step(); step();
        @(negedge clk);
        chk("rst_btb_en", btb_en, 0);
        chk("rst_busy", flush_busy, 1);
        chk("rst_done", flush_done, 0);
        chk("rst_mem_we", mem_we, 1);
        chk("rst_mem_idx", mem_idx, 0);
        chk("rst_stat", stat_rdata, 0);

        // Reset release: cycle 0 starts here
        step();
        rst_n = 1;
        errs = 0; rise = -1; ndone = 0; done_cyc = -1;
        for (int c = 0; c < 520; c++) begin
            @(negedge clk);
            if (c < 512 && !(mem_we === 1'b1 && mem_idx === IDX_W'(c) && mem_wdata === '0))
                errs++;
            if ((c == 512 || c == 513) && (mem_we !== 1'b0 || flush_busy !== 1'b1))
                errs++;
            if (btb_en === 1'b1 && rise < 0) rise = c;
            if (flush_done === 1'b1) begin
                ndone++;
                done_cyc = c;
            end
            step();
        end
        chk("walk_errs", errs, 0);
        chk("btb_en_rise", rise, 514);
        chk("done_count", ndone, 1);
        chk("done_cycle", done_cyc, 514);

        // Update pass-through in RUN
        upd_we = 1; upd_idx = 9'h07F; upd_wdata = 25'h0A5123;
        @(negedge clk);
        chk("upd_we", mem_we, 1);
        chk("upd_idx", mem_idx, 9'h07F);
        chk("upd_wdata", mem_wdata, 25'h0A5123);
        chk("run_busy", flush_busy, 0);
        step();
        upd_we = 0;
        @(negedge clk);
        chk("idle_we", mem_we, 0);

        // Flush in RUN with a coincident update, then restart 100 cycles later
        step();
        flush_req = 1; upd_we = 1; upd_idx = 9'h010; upd_wdata = 25'h001234;
        @(negedge clk);
        chk("flush_upd_we", mem_we, 1);
        chk("flush_upd_data", mem_wdata, 25'h001234);
        step();
        flush_req = 0; upd_we = 0;
        rise = -1; ndone = 0;
        for (int k = 1; k <= 620; k++) begin
            flush_req = (k == 100);
            @(negedge clk);
            if (k == 1) chk("reflush_idx0", mem_idx, 0);
            if (k == 100) chk("reflush_idx99", mem_idx, 99);
            if (k == 101) chk("restart_idx0", mem_idx, 0);
            if (btb_en === 1'b1 && rise < 0) rise = k;
            if (flush_done === 1'b1) ndone++;
            step();
        end
        flush_req = 0;
        chk("reflush_rise", rise, 615);
        chk("reflush_done", ndone, 1);

        // Updates during FLUSH are dropped and counted; bump two other counters too
        flush_req = 1;
        step();
        flush_req = 0;
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            upd_we = 1; upd_idx = 9'h055; upd_wdata = 25'h1FFFFFF;
            inc_br_cnt = (k < 3);
            inc_mispr_cnt = (k < 2);
            @(negedge clk);
            if (mem_wdata !== '0 || mem_idx !== IDX_W'(k)) errs++;
            step();
        end
        upd_we = 0; inc_br_cnt = 0; inc_mispr_cnt = 0;
        chk("drop_nodata", errs, 0);
        stat_sel = 2'd3;
        @(negedge clk);
        chk("drop_cnt", stat_rdata, 5);
        stat_sel = 2'd0;
        #1 chk("br_cnt", stat_rdata, 3);
        stat_sel = 2'd1;
        #1 chk("hit_cnt0", stat_rdata, 0);
        stat_sel = 2'd2;
        #1 chk("mispr_cnt", stat_rdata, 2);

        // Hit counter saturation, then clear wins over increment
        step();
        inc_hit_cnt = 1; stat_sel = 2'd1;
        for (int k = 0; k < 70000; k++) step();
        @(negedge clk);
        chk("hit_sat", stat_rdata, 16'hFFFF);
        step();
        stat_clr = 1;
        step();
        stat_clr = 0; inc_hit_cnt = 0;
        @(negedge clk);
        chk("hit_clr", stat_rdata, 0);
        stat_sel = 2'd3;
        #1 chk("drop_clr", stat_rdata, 0);

        // Reset in the middle of a clear walk
        step();
        flush_req = 1; inc_br_cnt = 1;
        step();
        flush_req = 0; inc_br_cnt = 0;
        for (int k = 0; k < 300; k++) step();
        stat_sel = 2'd0;
        @(negedge clk);
        chk("mid_idx300", mem_idx, 300);
        chk("mid_br", stat_rdata, 1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_idx", mem_idx, 0);
        chk("mid_rst_we", mem_we, 1);
        chk("mid_rst_busy", flush_busy, 1);
        chk("mid_rst_en", btb_en, 0);
        chk("mid_rst_cnt", stat_rdata, 0);
        step();
        rst_n = 1;
        @(negedge clk);
        chk("rel_idx0", mem_idx, 0);
        step();
        @(negedge clk);
        chk("rel_idx1", mem_idx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
